// File: rtl/sopc_wait_ram.sv
// sopc_wait_ram: parametrised data RAM with base-address decode, programmable wait states
// and a ce/stall/ack handshake.
module sopc_wait_ram #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 15,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [DATA_W/8-1:0] sel,
    input  logic [DATA_W-1:0]   data_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                stall_o
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                in_q, in_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [NB-1:0]       sel_q, sel_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   data_o_q, data_o_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic [31:0]         off;
    logic                in_rng;
    logic                idle;
    logic                go_resp;
    logic                cur_we;
    logic                cur_in;
    logic [ADDR_W-1:0]   cur_idx;
    logic [NB-1:0]       cur_sel;
    logic [DATA_W-1:0]   cur_wdat;
    logic [DATA_W-1:0]   lane_mask;
    logic [DATA_W-1:0]   rd_word;

    // With zero wait states RESP is entered straight from IDLE, so the live inputs
    // stand in for the not-yet-latched request.
    always_comb begin
        off      = addr - BASE_ADDR;
        in_rng   = (off >> (ADDR_W + 2)) == 32'd0;
        idle     = state_q == S_IDLE;
        cur_we   = idle ? we : we_q;
        cur_in   = idle ? in_rng : in_q;
        cur_idx  = idle ? off[ADDR_W+1:2] : idx_q;
        cur_sel  = idle ? sel : sel_q;
        cur_wdat = idle ? data_i : wdat_q;
        for (int i = 0; i < NB; i++) lane_mask[8*i +: 8] = {8{cur_sel[i]}};
        rd_word  = mem[cur_idx] & lane_mask;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        in_d    = in_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        go_resp = 1'b0;
        case (state_q)
            S_IDLE: if (ce) begin
                we_d    = we;
                in_d    = in_rng;
                idx_d   = off[ADDR_W+1:2];
                sel_d   = sel;
                wdat_d  = data_i;
                cnt_d   = WAIT_N;
                go_resp = WAIT_N == 4'd0;
                state_d = go_resp ? S_RESP : S_WAIT;
            end
            S_WAIT: if (!ce) begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end else begin
                cnt_d   = cnt_q - 4'd1;
                go_resp = cnt_q == 4'd1;
                state_d = go_resp ? S_RESP : S_WAIT;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        ack_d    = go_resp;
        err_d    = go_resp & ~cur_in;
        data_o_d = (go_resp && !cur_we && cur_in) ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            in_q     <= 1'b0;
            idx_q    <= '0;
            sel_q    <= '0;
            wdat_q   <= '0;
            data_o_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            in_q     <= in_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            wdat_q   <= wdat_d;
            data_o_q <= data_o_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    // Array is never cleared; rst gates the commit so a reset edge cannot write.
    always_ff @(posedge clk) begin
        if (go_resp && rst && cur_we && cur_in)
            for (int i = 0; i < NB; i++)
                if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_wdat[8*i +: 8];
    end

    assign data_o  = data_o_q;
    assign ack_o   = ack_q;
    assign err_o   = err_q;
    assign stall_o = ce & ~ack_q;
endmodule
